// File: rtl/codec_dac_serializer_pkg.sv
// Shared definitions for the WM8731 DAC serializer.
// Audio format codes and serializer FSM states.
package codec_dac_serializer_pkg;

    typedef enum logic [1:0] {
        MODE_I2S = 2'd0,
        MODE_LJ  = 2'd1,
        MODE_RJ  = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/codec_dac_serializer_if.sv
// Stereo frame push bus into the DAC serializer.
// The master offers a left/right pair; the slave accepts when not full.
interface codec_dac_serializer_if #(
    parameter int DATA_W = 24
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );
endinterface

// File: rtl/codec_sample_fifo.sv
// Synchronous stereo-frame FIFO.
// Pushes while full and pops while empty are ignored.
module codec_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];
    assign level   = level_q;

    // Next storage, pointer and occupancy from accepted push/pop.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/codec_dac_serializer.sv
// WM8731 master-mode DAC serializer: BCLK/DACLRC/DACDAT generation
// from buffered stereo frames, with I2S/LJ/RJ formats and underrun count.
module codec_dac_serializer
    import codec_dac_serializer_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int DEPTH    = 8,
    parameter int BCLK_DIV = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    codec_dac_serializer_if.slave      s,
    output logic                       dac_bclk,
    output logic                       dac_lrc,
    output logic                       dac_dat,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       underrun,
    output logic [15:0]                underrun_cnt
);
    localparam int BW = $clog2(2*SLOT_W);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int IW = $clog2(DATA_W);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     b_q, b_d;
    logic              bclk_q, bclk_d;
    logic              lrc_q, lrc_d;
    logic              dat_q, dat_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              und_q, und_d;
    logic [15:0]       ucnt_q, ucnt_d;

    logic [BW-1:0]       b_nx;
    logic                start;
    logic                stop;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_dout;

    // Offset of bit index b inside its channel slot.
    function automatic logic [BW-1:0] slot_k(input logic [BW-1:0] b);
        return (b >= BW'(SLOT_W)) ? b - BW'(SLOT_W) : b;
    endfunction

    // Serial bit for slot offset k under the given format; 0 outside the sample.
    function automatic logic data_bit(
        input logic [DATA_W-1:0] smp,
        input mode_e             md,
        input logic [BW-1:0]     k
    );
        logic          hit;
        logic [BW-1:0] pos;
        case (md)
            MODE_LJ: begin
                hit = (k < BW'(DATA_W));
                pos = BW'(DATA_W-1) - k;
            end
            MODE_RJ: begin
                hit = (k >= BW'(SLOT_W-DATA_W));
                pos = BW'(SLOT_W-1) - k;
            end
            default: begin
                hit = (k != '0) && (k <= BW'(DATA_W));
                pos = BW'(DATA_W) - k;
            end
        endcase
        return hit & smp[IW'(pos)];
    endfunction

    assign s.s_ready = ~fifo_full;
    assign fifo_push = s.s_valid & ~fifo_full;

    codec_sample_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({s.s_left, s.s_right}),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, BCLK divider, bit sequencing and frame start/stop.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        div_d    = div_q;
        b_d      = b_q;
        bclk_d   = bclk_q;
        lrc_d    = lrc_q;
        dat_d    = dat_q;
        left_d   = left_q;
        right_d  = right_q;
        und_d    = 1'b0;
        ucnt_d   = ucnt_q;
        fifo_pop = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        b_nx     = b_q + BW'(1);

        case (state_q)
            IDLE: begin
                bclk_d = 1'b0;
                lrc_d  = 1'b0;
                dat_d  = 1'b0;
                div_d  = '0;
                b_d    = '0;
                start  = en;
            end
            RUN: begin
                if (div_q == DW'(BCLK_DIV-1)) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // BCLK falling edge: advance to the next bit.
                    if (bclk_q) begin
                        if (b_q == BW'(2*SLOT_W-1)) begin
                            start = en;
                            stop  = ~en;
                        end else begin
                            b_d   = b_nx;
                            lrc_d = (b_nx >= BW'(SLOT_W));
                            dat_d = data_bit(lrc_d ? right_q : left_q,
                                             mode_q, slot_k(b_nx));
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop only sees frames already stored before this edge.
        if (start) begin
            state_d = RUN;
            div_d   = '0;
            b_d     = '0;
            bclk_d  = 1'b0;
            lrc_d   = 1'b0;
            mode_d  = mode_e'(mode);
            if (!fifo_empty) begin
                fifo_pop          = 1'b1;
                {left_d, right_d} = fifo_dout;
            end else begin
                left_d  = '0;
                right_d = '0;
                und_d   = 1'b1;
                if (ucnt_q != 16'hFFFF) begin
                    ucnt_d = ucnt_q + 16'd1;
                end
            end
            dat_d = data_bit(left_d, mode_d, '0);
        end

        if (stop) begin
            state_d = IDLE;
            bclk_d  = 1'b0;
            lrc_d   = 1'b0;
            dat_d   = 1'b0;
            div_d   = '0;
            b_d     = '0;
        end
    end

    // Serializer registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_I2S;
            div_q   <= '0;
            b_q     <= '0;
            bclk_q  <= 1'b0;
            lrc_q   <= 1'b0;
            dat_q   <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
            und_q   <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            b_q     <= b_d;
            bclk_q  <= bclk_d;
            lrc_q   <= lrc_d;
            dat_q   <= dat_d;
            left_q  <= left_d;
            right_q <= right_d;
            und_q   <= und_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign dac_bclk     = bclk_q;
    assign dac_lrc      = lrc_q;
    assign dac_dat      = dat_q;
    assign underrun     = und_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_codec_dac_serializer.sv
// Bench for codec_dac_serializer: frame-level reference model feeding
// an expected-bit scoreboard checked at every BCLK rising edge.
module tb_codec_dac_serializer;
    localparam int DATA_W    = 24;
    localparam int SLOT_W    = 32;
    localparam int DEPTH     = 8;
    localparam int BCLK_DIV  = 8;
    localparam int FRAME_CLK = 4*SLOT_W*BCLK_DIV;
    localparam int LW        = $clog2(DEPTH+1);

    typedef struct {
        logic [1:0] v;
        bit         cont;
        int         fr;
        int         b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          dac_bclk;
    logic          dac_lrc;
    logic          dac_dat;
    logic [LW-1:0] fifo_level;
    logic          underrun;
    logic [15:0]   underrun_cnt;

    codec_dac_serializer_if #(.DATA_W(DATA_W)) bus ();

    codec_dac_serializer #(
        .DATA_W   (DATA_W),
        .SLOT_W   (SLOT_W),
        .DEPTH    (DEPTH),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .s            (bus),
        .dac_bclk     (dac_bclk),
        .dac_lrc      (dac_lrc),
        .dac_dat      (dac_dat),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {lrc, dat} for bit index b of a frame, from the format rules.
    function automatic logic [1:0] exp_bit(input logic [2*DATA_W-1:0] fr,
                                           input logic [1:0] md,
                                           input int b);
        logic              lrc;
        logic              d;
        logic [DATA_W-1:0] smp;
        logic [DATA_W-1:0] t;
        int                k;
        int                pos;
        lrc = (b >= SLOT_W);
        smp = lrc ? fr[DATA_W-1:0] : fr[2*DATA_W-1:DATA_W];
        k   = b % SLOT_W;
        pos = -1;
        case (md)
            2'd1: if (k < DATA_W) pos = DATA_W-1-k;
            2'd2: if (k >= SLOT_W-DATA_W) pos = DATA_W-1-(k-(SLOT_W-DATA_W));
            default: if (k >= 1 && k <= DATA_W) pos = DATA_W-1-(k-1);
        endcase
        d = 1'b0;
        if (pos >= 0) begin
            t = smp >> pos;
            d = t[0];
        end
        return {lrc, d};
    endfunction

    logic [2*DATA_W-1:0] m_fifo[$];
    exp_t                exp_q[$];
    bit                  m_run = 0;
    int                  m_cnt = 0;
    int                  m_ucnt = 0;
    logic                m_upulse = 1'b0;
    int                  m_frame = 0;

    task automatic frame_start(input bit cont);
        logic [2*DATA_W-1:0] fr;
        exp_t                e;
        if (m_fifo.size() > 0) begin
            fr = m_fifo.pop_front();
        end else begin
            fr       = '0;
            m_upulse = 1'b1;
            if (m_ucnt != 65535) m_ucnt++;
        end
        for (int b = 0; b < 2*SLOT_W; b++) begin
            e.v    = exp_bit(fr, mode, b);
            e.cont = cont || (b > 0);
            e.fr   = m_frame;
            e.b    = b;
            exp_q.push_back(e);
        end
        m_frame++;
    endtask

    // Frame-level reference: frame starts every FRAME_CLK clocks while enabled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run    = 0;
            m_cnt    = 0;
            m_ucnt   = 0;
            m_upulse = 1'b0;
            m_fifo.delete();
            exp_q.delete();
        end else begin
            m_upulse = 1'b0;
            if (!m_run) begin
                if (en) begin
                    frame_start(1'b0);
                    m_run = 1;
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt == FRAME_CLK) begin
                    m_cnt = 0;
                    if (en) frame_start(1'b1);
                    else m_run = 0;
                end
            end
            if (bus.s_valid && m_fifo.size() < DEPTH)
                m_fifo.push_back({bus.s_left, bus.s_right});
        end
    end

    int   cyc_n = 0;
    int   last_rise = 0;
    logic bclk_prev = 1'b0;
    exp_t mon_e;

    // Per-cycle status checks and serial-bit scoreboard on BCLK rises.
    always @(negedge clk) begin
        cyc_n++;
        chk("level", 32'(fifo_level), 32'(m_fifo.size()));
        chk("s_ready", 32'(bus.s_ready), 32'(m_fifo.size() != DEPTH));
        chk("underrun", 32'(underrun), 32'(m_upulse));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
        if (rst) begin
            bclk_prev = 1'b0;
        end else begin
            if (dac_bclk && !bclk_prev) begin
                chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("bit f%0d b%0d", mon_e.fr, mon_e.b),
                        32'({dac_lrc, dac_dat}), 32'(mon_e.v));
                    if (mon_e.cont)
                        chk("bclk_period", 32'(cyc_n - last_rise),
                            32'(2*BCLK_DIV));
                end
                last_rise = cyc_n;
            end
            bclk_prev = dac_bclk;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] l,
                              input logic [DATA_W-1:0] r);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_left  = l;
        bus.s_right = r;
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_bclk"}, 32'(dac_bclk), 32'd0);
        chk({tag, "_lrc"}, 32'(dac_lrc), 32'd0);
        chk({tag, "_dat"}, 32'(dac_dat), 32'd0);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_one(input logic [1:0] md, input string tag);
        push_frame(24'h842124, 24'h123456);
        mode = md;
        en   = 1'b1;
        wait_clk(200);
        en = 1'b0;
        wait_clk(1100);
        idle_check(tag);
    endtask

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        mode        = 2'd0;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;
        wait_clk(3);
        chk("rst_bclk", 32'(dac_bclk), 32'd0);
        chk("rst_lrc", 32'(dac_lrc), 32'd0);
        chk("rst_dat", 32'(dac_dat), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
        chk("rst_ready", 32'(bus.s_ready), 32'd1);
        rst = 1'b0;
        wait_clk(2);

        run_one(2'd0, "i2s");
        run_one(2'd1, "lj");
        run_one(2'd2, "rj");
        chk("no_underrun", 32'(underrun_cnt), 32'd0);

        push_frame(24'hA5C3F0, 24'h0F1E2D);
        push_frame(24'hFEDCBA, 24'h800001);
        mode = 2'd0;
        en   = 1'b1;
        wait_clk(300);
        mode = 2'd1;
        wait_clk(1024);
        en = 1'b0;
        wait_clk(1100);
        idle_check("mode_chg");
        mode = 2'd0;

        en = 1'b1;
        wait_clk(2548);
        chk("ucnt3", 32'(underrun_cnt), 32'd3);
        push_frame(24'h5A5A5A, 24'hC0FFEE);
        wait_clk(800);
        en = 1'b0;
        wait_clk(1100);
        idle_check("under");

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_left  = 24'h100000 + 24'(i) * 24'h011111;
            bus.s_right = 24'hF00000 - 24'(i) * 24'h010101;
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ready", 32'(bus.s_ready), 32'd0);
        en = 1'b1;
        wait_clk(7*FRAME_CLK + 300);
        en = 1'b0;
        wait_clk(1100);
        idle_check("full");

        @(negedge clk);
        en          = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_left  = 24'h13579B;
        bus.s_right = 24'h2468AC;
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("bnd_level", 32'(fifo_level), 32'd1);
        chk("bnd_underrun", 32'(underrun), 32'd1);
        chk("bnd_ucnt", 32'(underrun_cnt), 32'd4);
        wait_clk(1300);
        en = 1'b0;
        wait_clk(1100);
        idle_check("bnd");

        push_frame(24'hFFFFFF, 24'hFFFFFF);
        mode = 2'd1;
        en   = 1'b1;
        wait_clk(300);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_bclk", 32'(dac_bclk), 32'd0);
        chk("arst_lrc", 32'(dac_lrc), 32'd0);
        chk("arst_dat", 32'(dac_dat), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_ucnt", 32'(underrun_cnt), 32'd0);
        wait_clk(3);
        en  = 1'b0;
        rst = 1'b0;
        wait_clk(50);
        idle_check("post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/codec_dac_serializer.md
Name: codec_dac_serializer

Overview:
- Parametrised, synthesizable DAC audio serializer for the WM8731 controller.
- Buffers stereo frames pushed by the master-bus side, e.g. the 24-bit words written via setDACaudio.
- Drives codec BCLK, DACLRC and DACDAT in master mode from the 50 MHz system clock.
- Supports run-time selectable I2S, left-justified and right-justified formats, configurable sample/slot widths and FIFO depth, and underrun reporting.

Parameters:
- DATA_W, 24, audio sample width in bits (16..32).
- SLOT_W, 32, BCLK periods per channel slot. Requires SLOT_W >= DATA_W+1.
- DEPTH, 8, stereo frames held in the FIFO. Power of 2, >= 2.
- BCLK_DIV, 8, clk cycles per BCLK half-period. Default gives 3.125 MHz BCLK and 48.83 kHz fs.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  serializer run enable.
- mode  in  2  0=I2S, 1=left-justified, 2=right-justified, 3=treated as I2S.
- s_valid  in  1  frame push request.
- s_ready  out  1  FIFO not full.
- s_left  in  DATA_W  left sample.
- s_right  in  DATA_W  right sample.
- dac_bclk  out  1  codec bit clock.
- dac_lrc  out  1  DACLRC: 0=left slot, 1=right slot.
- dac_dat  out  1  DACDAT, MSB first.
- fifo_level  out  $clog2(DEPTH+1)  frames stored.
- underrun  out  1  one-clk pulse on an empty-FIFO frame start.
- underrun_cnt  out  16  saturating underrun count.

Behaviour:
- Reset values: dac_bclk=0, dac_lrc=0, dac_dat=0, fifo_level=0, underrun=0, underrun_cnt=0, bit index b=0, divider=0. FIFO emptied. State=IDLE.
- s_ready is combinational, equal to (fifo_level != DEPTH). It is 1 after reset.
- Push occurs when s_valid && s_ready at a clk edge. A push while full is dropped with no side effects.
- The FIFO operates whenever rst is low, independent of en.
- State machine: IDLE -> RUN -> IDLE.
- IDLE:
  - Outputs held at 0.
  - A clk edge with en=1 performs a frame start: pop or underrun, latch mode, b=0, divider cleared. Next state is RUN.
- RUN:
  - Divider counts 0..BCLK_DIV-1.
  - On wrap, dac_bclk toggles.
  - Each BCLK falling edge increments b, modulo 2*SLOT_W.
  - dac_lrc and dac_dat update on that same clk edge. The codec samples on the rising edge.
- Frame start:
  - Occurs at the falling edge where b wraps from 2*SLOT_W-1 to 0.
  - If en=0 at that edge, the FSM goes to IDLE instead, with all outputs 0. A frame in flight always completes.
  - Otherwise:
    - FIFO non-empty: pop the head into the left/right shift registers.
    - FIFO empty: load zeros, pulse underrun, and increment underrun_cnt, saturating at 16'hFFFF.
    - Latch mode. A mode change mid-frame has no effect until the next frame start.
- dac_lrc = (b >= SLOT_W).
- Data placement, with k the bit offset within the slot (b mod SLOT_W):
  - I2S: sample bit DATA_W-1-(k-1) for k in 1..DATA_W.
  - Left-justified: bit DATA_W-1-k for k in 0..DATA_W-1.
  - Right-justified: bit DATA_W-1-(k-(SLOT_W-DATA_W)) for k in SLOT_W-DATA_W..SLOT_W-1.
  - All other k: dac_dat=0.
- Simultaneous push and pop:
  - Both take effect; fifo_level is unchanged.
  - A push into an empty FIFO on a frame-start edge does not satisfy that pop. The frame underruns and the pushed frame remains.
- Async reset mid-frame: immediate return to reset values. The partial frame is discarded.

Decomposition:
- codec_defs.vh holds the constants:
  - MODE_I2S=2'd0, MODE_LJ=2'd1, MODE_RJ=2'd2.
  - FSM state encodings IDLE and RUN.
- Sub-module codec_sample_fifo:
  - Synchronous FIFO, width 2*DATA_W, parameter DEPTH.
  - Ports: push, pop, data in/out, level, full, empty. Same clk/rst.

Test Plan:
- Reset, then push L=24'h842124 and R=24'h123456, en=1, mode=0. The capture at dac_bclk rising edges must give:
  - Left: lrc=0, bit at k=0 is 0, then 24 bits 842124, then 7 zeros.
  - Right: lrc=1, same layout with 123456.
  - underrun stays 0.
- Same frame in mode=1 -> MSB at k=0. In mode=2 -> MSB at k=8, LSB at k=31. BCLK period is 16 clk and the LRC period is 1024 clk.
- en=1 with an empty FIFO for 3 frames -> dac_dat all 0, three underrun pulses, underrun_cnt=3. Then push one frame -> the next frame carries its data.
- Push 9 frames with en=0 -> the first 8 are accepted, s_ready=0, fifo_level=8, the 9th is dropped. Enable -> frames appear in push order, and s_ready returns to 1 after the first pop.
- Drop en mid-left-slot -> the frame completes to b=63, then outputs go to 0 and the FSM enters IDLE. Change mode mid-frame -> the format changes only at the next frame.
- Assert rst mid-frame -> on the same edge all outputs are 0, fifo_level=0, underrun_cnt=0.
